piso_tx: RTL and testbench

- Parallel-in serial-out transmitter for a serial-in shift-register receiver with ports clk, reset, serial_in and q.
- Accepts a WIDTH-bit word through a valid/ready handshake and drives it one bit per clock on serial_out.
- Bit order matches the receiver's shift direction: MSB first by default, so after WIDTH samples the receiver's q equals the sent word.
- Back-to-back words stream with no idle gap.

---
 rtl/piso_pkg.sv | 12 +
 rtl/piso_tx.sv | 123 ++++++++++++
 tb/tb_piso_tx.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/piso_pkg.sv
// Shared types for the piso_tx transmitter and receiver-side loopback benches.
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } piso_state_t;

  localparam int PISO_WIDTH_DEF = 4;

endpackage

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: valid/ready word load, one bit per clock, gapless streaming.
// Optional even-parity trailer cycle when PISO_TX_PARITY_EN is defined.
module piso_tx
  import piso_pkg::*;
#(
  parameter int WIDTH     = PISO_WIDTH_DEF,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             serial_out,
  output logic             frame_valid,
  output logic             last_bit,
  output piso_state_t      dbg_state
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  // Handshake: a word moves when load_valid && load_ready at a rising edge;
  // the source must hold data_in stable until then, and data_in is ignored otherwise.
  piso_state_t      r_state;
  logic [WIDTH-2:0] r_shift;
  logic [CW-1:0]    r_cnt;
  logic             r_serial;
  logic             r_fv;
  logic             r_last;
`ifdef PISO_TX_PARITY_EN
  logic             r_parity;
`endif

  logic             w_last_data;
  logic             w_ready_state;
  logic             w_accept;
  logic             w_first_bit;
  logic [WIDTH-2:0] w_rest;
  logic             w_next_bit;
  logic [WIDTH-2:0] w_shifted;

  assign w_last_data = (r_state == SHIFT) && (r_cnt == LAST_CNT);
`ifdef PISO_TX_PARITY_EN
  assign w_ready_state = (r_state == IDLE) || (r_state == PARITY);
`else
  assign w_ready_state = (r_state == IDLE) || w_last_data;
`endif
  assign load_ready = !reset && w_ready_state;
  assign w_accept   = load_valid && load_ready;

  // The first bit goes straight to serial_out; the shift register only holds what remains.
  assign w_first_bit = MSB_FIRST ? data_in[WIDTH-1]   : data_in[0];
  assign w_rest      = MSB_FIRST ? data_in[WIDTH-2:0] : data_in[WIDTH-1:1];
  assign w_next_bit  = MSB_FIRST ? r_shift[WIDTH-2]   : r_shift[0];
  assign w_shifted   = MSB_FIRST ? (r_shift << 1)     : (r_shift >> 1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_shift  <= '0;
      r_cnt    <= '0;
      r_serial <= 1'b0;
      r_fv     <= 1'b0;
      r_last   <= 1'b0;
`ifdef PISO_TX_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else if (w_accept) begin
      r_state  <= SHIFT;
      r_shift  <= w_rest;
      r_cnt    <= '0;
      r_serial <= w_first_bit;
      r_fv     <= 1'b1;
      r_last   <= 1'b0;
`ifdef PISO_TX_PARITY_EN
      r_parity <= ^data_in;
`endif
    end else begin
      case (r_state)
        SHIFT: begin
          if (r_cnt == LAST_CNT) begin
`ifdef PISO_TX_PARITY_EN
            r_state  <= PARITY;
            r_serial <= r_parity;
            r_fv     <= 1'b1;
            r_last   <= 1'b1;
`else
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_serial <= 1'b0;
            r_fv     <= 1'b0;
            r_last   <= 1'b0;
`endif
          end else begin
            r_serial <= w_next_bit;
            r_shift  <= w_shifted;
            r_cnt    <= r_cnt + CW'(1);
`ifdef PISO_TX_PARITY_EN
            r_last   <= 1'b0;
`else
            r_last   <= ((r_cnt + CW'(1)) == LAST_CNT);
`endif
          end
        end
        default: begin
          // IDLE, or the parity cycle ending without a follow-on word
          r_state  <= IDLE;
          r_cnt    <= '0;
          r_serial <= 1'b0;
          r_fv     <= 1'b0;
          r_last   <= 1'b0;
        end
      endcase
    end
  end

  assign serial_out  = r_serial;
  assign frame_valid = r_fv;
  assign last_bit    = r_last;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: MSB-first and LSB-first instances against a bit-queue model plus receiver loopback.
module tb_piso_tx;
  import piso_pkg::*;

  localparam int W = 4;
`ifdef PISO_TX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [W-1:0] data_in = '0;
  logic         load_valid = 1'b0;
  logic         m_ready, m_so, m_fv, m_lb;
  logic         l_ready, l_so, l_fv, l_lb;
  piso_state_t  m_st, l_st;

  piso_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .data_in(data_in), .load_valid(load_valid),
    .load_ready(m_ready), .serial_out(m_so), .frame_valid(m_fv),
    .last_bit(m_lb), .dbg_state(m_st)
  );

  piso_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .data_in(data_in), .load_valid(load_valid),
    .load_ready(l_ready), .serial_out(l_so), .frame_valid(l_fv),
    .last_bit(l_lb), .dbg_state(l_st)
  );

  // receivers: MSB-first shifts left, LSB-first shifts right
  logic [W-1:0] rx_m = '0;
  logic [W-1:0] rx_l = '0;
  always @(posedge clk) begin
    if (m_fv) rx_m <= {rx_m[W-2:0], m_so};
    if (l_fv) rx_l <= {l_so, rx_l[W-1:1]};
  end

  // scoreboard: each entry is {last, bit} for one serial cycle; head = bit on the wire now
  logic [1:0]   exp_m_q[$];
  logic [1:0]   exp_l_q[$];
  logic [W-1:0] exp_rxm_q[$];
  logic [W-1:0] exp_rxl_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_state(input int size, input logic [1:0] head);
    if (size == 0) return 32'(IDLE);
    if (PAR && size == 1) return 32'(PARITY);
    return 32'(SHIFT);
  endfunction

  task automatic check_side(input string side, input logic [1:0] q[$], input logic rdy,
                            input logic so, input logic fv, input logic lb, input piso_state_t st);
    logic [1:0] head;
    head = (q.size() > 0) ? q[0] : 2'b00;
    check({side, "_ready"},       32'(rdy), 32'(!reset && q.size() <= 1));
    check({side, "_frame_valid"}, 32'(fv),  32'(q.size() > 0));
    check({side, "_serial_out"},  32'(so),  32'(head[0]));
    check({side, "_last_bit"},    32'(lb),  32'(head[1]));
    check({side, "_state"},       32'(st),  exp_state(q.size(), head));
  endtask

  task automatic push_word(input logic [W-1:0] w);
    logic p;
    p = ^w;
    for (int i = W - 1; i >= 0; i--) exp_m_q.push_back({(i == 0) && !PAR, w[i]});
    for (int i = 0; i < W; i++)      exp_l_q.push_back({(i == W - 1) && !PAR, w[i]});
    if (PAR) begin
      exp_m_q.push_back({1'b1, p});
      exp_l_q.push_back({1'b1, p});
      exp_rxm_q.push_back({w[W-2:0], p});
      exp_rxl_q.push_back({p, w[W-1:1]});
    end else begin
      exp_rxm_q.push_back(w);
      exp_rxl_q.push_back(w);
    end
  endtask

  // One clock: check at the falling edge, advance the model at the rising edge.
  task automatic step(output logic acc);
    logic [1:0] popped;
    logic       rdy;
    @(negedge clk);
    check_side("msb", exp_m_q, m_ready, m_so, m_fv, m_lb, m_st);
    check_side("lsb", exp_l_q, l_ready, l_so, l_fv, l_lb, l_st);
    rdy = !reset && exp_m_q.size() <= 1;
    acc = load_valid && rdy;
    popped = 2'b00;
    @(posedge clk);
    if (reset) begin
      exp_m_q.delete(); exp_l_q.delete(); exp_rxm_q.delete(); exp_rxl_q.delete();
    end else begin
      if (exp_m_q.size() > 0) begin
        popped = exp_m_q.pop_front();
        void'(exp_l_q.pop_front());
      end
      if (acc) push_word(data_in);
    end
    #1;
    if (popped[1]) begin
      check("loopback_msb", 32'(rx_m), 32'(exp_rxm_q.pop_front()));
      check("loopback_lsb", 32'(rx_l), 32'(exp_rxl_q.pop_front()));
    end
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(acc);
  endtask

  // driver: present a word and hold it until accepted, bounded
  task automatic send(input logic [W-1:0] w, input bit drop_valid);
    logic acc;
    int   n;
    load_valid = 1'b1;
    data_in    = w;
    n = 0;
    do begin
      step(acc);
      n++;
    end while (!acc && n < 20);
    if (!acc) check("send_timeout", 32'(0), 32'(1));
    if (drop_valid) begin
      load_valid = 1'b0;
      data_in    = W'($urandom);
    end
  endtask

  initial begin
    logic acc;
    @(posedge clk);
    #1;
    idle(2);
    reset = 1'b0;
    idle(1);

    // single word, then drain
    send(4'b1011, 1'b1);
    idle(W + 3);

    // back-to-back with load_valid held high
    send(4'b1011, 1'b0);
    send(4'b0110, 1'b1);
    idle(W + 3);

    // hold-off: new word raised mid-frame
    send(4'b1011, 1'b1);
    idle(1);
    send(4'b1111, 1'b1);
    idle(W + 3);

    // data_in wiggling with no valid
    for (int i = 0; i < 4; i++) begin
      data_in = W'($urandom);
      step(acc);
    end

    // reset mid-frame, with load_valid asserted during reset
    send(4'b1011, 1'b1);
    idle(1);
    reset      = 1'b1;
    load_valid = 1'b1;
    data_in    = 4'b0110;
    idle(2);
    reset      = 1'b0;
    load_valid = 1'b0;
    idle(3);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      send(W'($urandom), $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 3) == 0) begin
        load_valid = 1'b0;
        idle($urandom_range(0, W + 2));
      end
    end
    load_valid = 1'b0;
    idle(W + 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
